mem_dma: RTL and testbench

MEM_DMA -- requirements
Module: mem_dma

---
 rtl/mem_dma.sv | 162 ++++++++++++++++
 tb/tb_mem_dma.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dma.sv
// Word-granular memory DMA engine: copies a block of 32-bit words from src to
// dst (read, then write, for each word) or fills dst with a constant pattern.
// The memory interface is driven purely from registered state; the read data
// comes back combinationally in the same cycle and is captured into a buffer.
module mem_dma #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             mode_i,
  input  logic [31:0]      src_i,
  input  logic [31:0]      dst_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      fill_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  input  logic [31:0]      mem_data_i
);

  // The transfer mode is carried by the state itself (RD/WR for copy, FILL
  // for fill), so it needs no separate register after the start edge.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    FILL = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] WORD_STEP = 32'd4;

  state_t             state_reg,   state_next;
  logic [31:0]        src_ptr_reg, src_ptr_next;
  logic [31:0]        dst_ptr_reg, dst_ptr_next;
  logic [LEN_W-1:0]   count_reg,   count_next;
  logic [31:0]        buf_reg,     buf_next;
  logic [31:0]        fill_reg,    fill_next;
  logic               aborted_reg, aborted_next;

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_reg   <= IDLE;
      src_ptr_reg <= '0;
      dst_ptr_reg <= '0;
      count_reg   <= '0;
      buf_reg     <= '0;
      fill_reg    <= '0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      src_ptr_reg <= src_ptr_next;
      dst_ptr_reg <= dst_ptr_next;
      count_reg   <= count_next;
      buf_reg     <= buf_next;
      fill_reg    <= fill_next;
      aborted_reg <= aborted_next;
    end
  end

  // Next-state logic plus memory/status outputs; outputs depend on registers only.
  always_comb begin
    state_next   = state_reg;
    src_ptr_next = src_ptr_reg;
    dst_ptr_next = dst_ptr_reg;
    count_next   = count_reg;
    buf_next     = buf_reg;
    fill_next    = fill_reg;
    aborted_next = aborted_reg;

    busy_o       = 1'b0;
    done_o       = 1'b0;
    aborted_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          src_ptr_next = src_i & WORD_MASK;
          dst_ptr_next = dst_i & WORD_MASK;
          count_next   = len_i;
          fill_next    = fill_i;
          aborted_next = 1'b0;
          if (len_i == '0) begin
            state_next = DONE;
          end else if (mode_i) begin
            state_next = FILL;
          end else begin
            state_next = RD;
          end
        end
      end

      RD: begin
        busy_o     = 1'b1;
        mem_addr_o = src_ptr_reg;
        buf_next   = mem_data_i;
        if (abort_i) begin
          aborted_next = 1'b1;
          state_next   = DONE;
        end else begin
          state_next   = WR;
        end
      end

      WR: begin
        busy_o       = 1'b1;
        mem_we_o     = 1'b1;
        mem_addr_o   = dst_ptr_reg;
        mem_data_o   = buf_reg;
        src_ptr_next = src_ptr_reg + WORD_STEP;
        dst_ptr_next = dst_ptr_reg + WORD_STEP;
        count_next   = count_reg - LEN_W'(1);
        if (abort_i) begin
          aborted_next = 1'b1;
          state_next   = DONE;
        end else if (count_reg == LEN_W'(1)) begin
          state_next   = DONE;
        end else begin
          state_next   = RD;
        end
      end

      FILL: begin
        busy_o       = 1'b1;
        mem_we_o     = 1'b1;
        mem_addr_o   = dst_ptr_reg;
        mem_data_o   = fill_reg;
        dst_ptr_next = dst_ptr_reg + WORD_STEP;
        count_next   = count_reg - LEN_W'(1);
        if (abort_i) begin
          aborted_next = 1'b1;
          state_next   = DONE;
        end else if (count_reg == LEN_W'(1)) begin
          state_next   = DONE;
        end
      end

      DONE: begin
        busy_o       = 1'b1;
        done_o       = 1'b1;
        aborted_o    = aborted_reg;
        aborted_next = 1'b0;
        state_next   = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_dma.sv
// Randomized bench for mem_dma: a word RAM answers reads combinationally, and
// a reference model predicts the per-cycle bus trace and final RAM image from
// the transfer rules (word index arithmetic, ordered copy, abort cut-off).
module tb_mem_dma;
  localparam int LEN_W = 16;
  localparam int MAXC  = 256;
  localparam int WORDS = 4096;

  logic             clk = 1'b0;
  logic             rst_;
  logic             start_i;
  logic             abort_i;
  logic             mode_i;
  logic [31:0]      src_i;
  logic [31:0]      dst_i;
  logic [LEN_W-1:0] len_i;
  logic [31:0]      fill_i;
  logic             busy_o;
  logic             done_o;
  logic             aborted_o;
  logic             mem_we_o;
  logic [31:0]      mem_addr_o;
  logic [31:0]      mem_data_o;
  logic [31:0]      mem_data_i;

  logic [31:0] ram  [WORDS];
  logic [31:0] mref [WORDS];

  bit          e_busy [MAXC];
  bit          e_done [MAXC];
  bit          e_ab   [MAXC];
  bit          e_we   [MAXC];
  bit          e_ca   [MAXC];
  bit          e_cd   [MAXC];
  logic [31:0] e_addr [MAXC];
  logic [31:0] e_data [MAXC];

  int n_checks = 0;
  int n_errors = 0;
  int txn = 0;

  mem_dma #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .mode_i     (mode_i),
    .src_i      (src_i),
    .dst_i      (dst_i),
    .len_i      (len_i),
    .fill_i     (fill_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .aborted_o  (aborted_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i)
  );

  always #5 clk = ~clk;

  function automatic int idx(input logic [31:0] a);
    return int'((a >> 2) & 32'h0000_0FFF);
  endfunction

  assign mem_data_i = ram[idx(mem_addr_o)];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to the middle of the next cycle and let the RAM take that cycle's write.
  task automatic step();
    @(negedge clk);
    if (mem_we_o) ram[idx(mem_addr_o)] = mem_data_o;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, 32'(busy_o), 32'd0);
    check({tag, " done"}, 32'(done_o), 32'd0);
    check({tag, " ab"},   32'(aborted_o), 32'd0);
    check({tag, " we"},   32'(mem_we_o), 32'd0);
    check({tag, " addr"}, mem_addr_o, 32'd0);
    check({tag, " data"}, mem_data_o, 32'd0);
  endtask

  task automatic check_ram(input string tag);
    int diffs = 0;
    for (int i = 0; i < WORDS; i++) if (ram[i] !== mref[i]) diffs++;
    check({tag, " ram_diffs"}, 32'(diffs), 32'd0);
  endtask

  // One transfer: predict the trace, drive it, compare every cycle.
  task automatic run(input bit mode, input logic [31:0] src, input logic [31:0] dst,
                     input int len, input logic [31:0] fill, input int abort_at,
                     input bit second);
    logic [31:0] s, d, w;
    int busy_n, done_k, i;
    bit ab;
    string p;
    txn++;
    s = src & 32'hFFFF_FFFC;
    d = dst & 32'hFFFF_FFFC;
    busy_n = mode ? len : 2 * len;
    ab     = (abort_at >= 1) && (abort_at <= busy_n);
    done_k = ab ? abort_at + 1 : busy_n + 1;

    for (int k = 1; k <= done_k + 1; k++) begin
      e_busy[k] = 1'b0; e_done[k] = 1'b0; e_ab[k] = 1'b0; e_we[k] = 1'b0;
      e_ca[k] = 1'b0; e_cd[k] = 1'b0; e_addr[k] = 32'd0; e_data[k] = 32'd0;
      if (k < done_k) begin
        e_busy[k] = 1'b1;
        if (mode) begin
          w = d + 32'(4 * (k - 1));
          e_we[k] = 1'b1; e_ca[k] = 1'b1; e_cd[k] = 1'b1;
          e_addr[k] = w; e_data[k] = fill;
          mref[idx(w)] = fill;
        end else if (k % 2 == 1) begin
          e_ca[k] = 1'b1;
          e_addr[k] = s + 32'(4 * ((k - 1) / 2));
        end else begin
          i = k / 2 - 1;
          w = d + 32'(4 * i);
          e_we[k] = 1'b1; e_ca[k] = 1'b1; e_cd[k] = 1'b1;
          e_addr[k] = w;
          e_data[k] = mref[idx(s + 32'(4 * i))];
          mref[idx(w)] = e_data[k];
        end
      end else if (k == done_k) begin
        e_busy[k] = 1'b1; e_done[k] = 1'b1; e_ab[k] = ab;
      end else begin
        e_ca[k] = 1'b1; e_cd[k] = 1'b1;
      end
    end

    mode_i = mode; src_i = src; dst_i = dst; len_i = LEN_W'(len); fill_i = fill;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 1; k <= done_k + 1; k++) begin
      p = $sformatf("t%0d c%0d", txn, k);
      check({p, " busy"}, 32'(busy_o), 32'(e_busy[k]));
      check({p, " done"}, 32'(done_o), 32'(e_done[k]));
      check({p, " ab"},   32'(aborted_o), 32'(e_ab[k]));
      check({p, " we"},   32'(mem_we_o), 32'(e_we[k]));
      if (e_ca[k]) check({p, " addr"}, mem_addr_o, e_addr[k]);
      if (e_cd[k]) check({p, " data"}, mem_data_o, e_data[k]);
      abort_i = (k == abort_at);
      if (second && done_k >= 2 && k == 2) begin
        start_i = 1'b1; mode_i = 1'b1; dst_i = 32'h0; len_i = LEN_W'(5); fill_i = $urandom;
      end else begin
        start_i = 1'b0;
      end
      step();
    end
    abort_i = 1'b0;
    start_i = 1'b0;
    check_ram($sformatf("t%0d", txn));
    $display("txn %0d mode=%0d src=%h dst=%h len=%0d abort_at=%0d second=%0d errors=%0d",
             txn, mode, src, dst, len, abort_at, second, n_errors);
  endtask

  // Reset asserted during a WR cycle of a copy.
  task automatic reset_mid();
    txn++;
    mode_i = 1'b0; src_i = 32'h100; dst_i = 32'h300; len_i = LEN_W'(4); fill_i = 32'h0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("rst c1 busy", 32'(busy_o), 32'd1);
    check("rst c1 addr", mem_addr_o, 32'h100);
    step();
    check("rst c2 we", 32'(mem_we_o), 32'd1);
    check("rst c2 addr", mem_addr_o, 32'h300);
    mref[idx(32'h300)] = mref[idx(32'h100)];
    rst_ = 1'b0;
    step();
    rst_ = 1'b1;
    check_idle("rst c3");
    for (int k = 4; k < 10; k++) begin
      step();
      check_idle($sformatf("rst c%0d", k));
    end
    check_ram("rst");
    $display("txn %0d reset during WR errors=%0d", txn, n_errors);
  endtask

  initial begin
    int len, busy_n, ab_at;
    bit mode;
    logic [31:0] src, dst;
    rst_ = 1'b0; start_i = 1'b1; abort_i = 1'b1; mode_i = 1'b1;
    src_i = 32'h10; dst_i = 32'h20; len_i = LEN_W'(7); fill_i = 32'h5A5A5A5A;
    for (int i = 0; i < WORDS; i++) begin
      ram[i]  = $urandom;
      mref[i] = ram[i];
    end
    ram[idx(32'h100)] = 32'hAAAA_0001; ram[idx(32'h104)] = 32'hBBBB_0002;
    ram[idx(32'h108)] = 32'hCCCC_0003; ram[idx(32'h10C)] = 32'hDDDD_0004;
    for (int i = 0; i < 4; i++) mref[idx(32'h100) + i] = ram[idx(32'h100) + i];

    step(); step(); step();
    check_idle("reset");
    rst_ = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    step();
    check_idle("post_reset");

    run(1'b0, 32'h100, 32'h200, 4, 32'h0, 0, 1'b0);
    run(1'b1, 32'h0, 32'h403, 3, 32'hDEAD_BEEF, 0, 1'b0);
    run(1'b0, 32'h100, 32'h500, 0, 32'h0, 0, 1'b0);
    run(1'b1, 32'h0, 32'h600, 0, 32'h1111_2222, 0, 1'b0);
    run(1'b1, 32'h0, 32'h800, 100, 32'h1234_5678, 5, 1'b1);
    run(1'b1, 32'h0, 32'hFFFF_FFF8, 3, 32'hCAFE_F00D, 0, 1'b0);
    run(1'b0, 32'h104, 32'h108, 4, 32'h0, 0, 1'b1);
    reset_mid();

    for (int r = 0; r < 24; r++) begin
      mode = 1'($urandom % 2);
      src  = $urandom & 32'h0000_3FFF;
      dst  = ($urandom % 3 == 0) ? src + 32'($urandom % 12) : ($urandom & 32'h0000_3FFF);
      len  = int'($urandom % 13);
      busy_n = mode ? len : 2 * len;
      ab_at  = ($urandom % 3 == 0) ? int'($urandom_range(1, busy_n + 1)) : 0;
      run(mode, src, dst, len, $urandom, ab_at, 1'($urandom % 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
